// File: rtl/matrix_framebuffer.sv
// ---------------------------------------------------------------------------
// matrix_framebuffer
//   Double-buffered pixel store for a 64x32 RGB LED matrix, upstream of the
//   scan driver. The back bank is written through a valid/ready pixel port or
//   flooded with one colour by the fill engine. The front bank is read by the
//   scan driver, one upper/lower pixel pair per read. Banks swap only on the
//   scan driver's frame_end pulse, so a displayed frame never tears.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   wr_valid/wr_ready   pixel write handshake; wr_x, wr_y, wr_rgb carry the pixel
//   clr_req, clr_rgb    start a fill of the whole back bank
//   clr_busy            fill in progress
//   swap_req            request a bank swap at the next frame_end
//   swap_pending        swap requested, not yet applied
//   frame_end           one-cycle pulse from the scan driver
//   front_sel           bank currently displayed
//   rd_en, rd_row, rd_col   scan read request
//   rd_valid, rd_top, rd_bot  read response (1-cycle latency)
// ---------------------------------------------------------------------------
module matrix_framebuffer #(
  parameter int COLS = 64,
  parameter int ROWS = 32,
  parameter int CW   = 6,
  parameter int RW   = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [CW-1:0] wr_x,
  input  logic [RW-1:0] wr_y,
  input  logic [2:0]    wr_rgb,
  input  logic          clr_req,
  input  logic [2:0]    clr_rgb,
  output logic          clr_busy,
  input  logic          swap_req,
  output logic          swap_pending,
  input  logic          frame_end,
  output logic          front_sel,
  input  logic          rd_en,
  input  logic [RW-2:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic          rd_valid,
  output logic [2:0]    rd_top,
  output logic [2:0]    rd_bot
);

  localparam int DEPTH = (ROWS / 2) * COLS;  // words per half per bank
  localparam int AW    = CW + RW - 1;        // word address within a half

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_e;

  state_e        state_q;
  logic          wr_ready_q;
  logic          clr_busy_q;
  logic          swap_pending_q;
  logic          front_sel_q;
  logic          rd_valid_q;
  logic [AW-1:0] clr_addr_q;
  logic [2:0]    clr_rgb_q;

  logic          wr_fire;
  logic          clr_active;
  logic [AW:0]   waddr;
  logic [AW:0]   raddr;
  logic [2:0]    wdata;

  // wr_ready is only ever high in IDLE, so a handshake implies IDLE.
  assign wr_fire    = wr_valid & wr_ready_q;
  assign clr_active = (state_q == CLEAR);

  // Bank index is the MSB of every memory address; writes target the back bank.
  assign waddr = clr_active ? {~front_sel_q, clr_addr_q}
                            : {~front_sel_q, wr_y[RW-2:0], wr_x};
  assign wdata = clr_active ? clr_rgb_q : wr_rgb;
  assign raddr = {front_sel_q, rd_row, rd_col};

  // Control FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      wr_ready_q     <= 1'b0;
      clr_busy_q     <= 1'b0;
      swap_pending_q <= 1'b0;
      front_sel_q    <= 1'b0;
      clr_addr_q     <= '0;
      clr_rgb_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q        <= CLEAR;
            clr_rgb_q      <= clr_rgb;
            clr_addr_q     <= '0;
            clr_busy_q     <= 1'b1;
            wr_ready_q     <= 1'b0;
            // A simultaneous swap is remembered and served after the fill.
            swap_pending_q <= swap_req;
          end else if (swap_req) begin
            state_q        <= SWAP_WAIT;
            swap_pending_q <= 1'b1;
            wr_ready_q     <= 1'b0;
          end else begin
            wr_ready_q     <= 1'b1;
          end
        end
        CLEAR: begin
          if (swap_req) begin
            swap_pending_q <= 1'b1;
          end
          clr_addr_q <= clr_addr_q + AW'(1);
          if (clr_addr_q == AW'(DEPTH - 1)) begin
            clr_busy_q <= 1'b0;
            if (swap_pending_q || swap_req) begin
              state_q <= SWAP_WAIT;
            end else begin
              state_q    <= IDLE;
              wr_ready_q <= 1'b1;
            end
          end
        end
        SWAP_WAIT: begin
          if (frame_end) begin
            front_sel_q    <= ~front_sel_q;
            swap_pending_q <= 1'b0;
            state_q        <= IDLE;
            wr_ready_q     <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wr_ready_q <= 1'b0;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
    end
  end

  // One RAM per half (gi=0 upper rows, gi=1 lower rows), both banks in each.
  // The fill writes both halves at once; a pixel write touches one half only.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      logic [2:0] mem [2*DEPTH];
      logic [2:0] pix_q;
      logic       we;

      assign we = clr_active | (wr_fire & (wr_y[RW-1] == 1'(gi)));

      // Storage is deliberately not reset.
      always_ff @(posedge clk) begin
        if (we) begin
          mem[waddr] <= wdata;
        end
      end

      // Read data holds its value when no read is issued.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pix_q <= '0;
        end else if (rd_en) begin
          pix_q <= mem[raddr];
        end
      end
    end
  endgenerate

  assign wr_ready     = wr_ready_q;
  assign clr_busy     = clr_busy_q;
  assign swap_pending = swap_pending_q;
  assign front_sel    = front_sel_q;
  assign rd_valid     = rd_valid_q;
  assign rd_top       = g_half[0].pix_q;
  assign rd_bot       = g_half[1].pix_q;

endmodule

// File: tb/tb_matrix_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_matrix_framebuffer
//   Directed self-checking bench for matrix_framebuffer: reset values, fill
//   engine length and colour, pixel writes and readback through a swap, swap
//   stall and handshake hold, same-cycle swap_req/frame_end, swap during a
//   fill, and reset in the middle of a fill.
// ---------------------------------------------------------------------------
module tb_matrix_framebuffer;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [5:0] wr_x;
  logic [4:0] wr_y;
  logic [2:0] wr_rgb;
  logic       clr_req;
  logic [2:0] clr_rgb;
  logic       clr_busy;
  logic       swap_req;
  logic       swap_pending;
  logic       frame_end;
  logic       front_sel;
  logic       rd_en;
  logic [3:0] rd_row;
  logic [5:0] rd_col;
  logic       rd_valid;
  logic [2:0] rd_top;
  logic [2:0] rd_bot;

  int n_checks = 0;
  int n_errors = 0;

  matrix_framebuffer dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_rgb       (wr_rgb),
    .clr_req      (clr_req),
    .clr_rgb      (clr_rgb),
    .clr_busy     (clr_busy),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .frame_end    (frame_end),
    .front_sel    (front_sel),
    .rd_en        (rd_en),
    .rd_row       (rd_row),
    .rd_col       (rd_col),
    .rd_valid     (rd_valid),
    .rd_top       (rd_top),
    .rd_bot       (rd_bot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    tick();
    swap_req  = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] row, input logic [5:0] col);
    rd_en  = 1'b1;
    rd_row = row;
    rd_col = col;
    tick();
    rd_en  = 1'b0;
    $display("read row=%0d col=%0d -> valid=%b top=%b bot=%b", row, col, rd_valid, rd_top, rd_bot);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_checks++;
    if ({wr_ready, clr_busy, swap_pending, front_sel, rd_valid, rd_top, rd_bot} !== 11'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b required 0", {wr_ready, clr_busy, swap_pending, front_sel, rd_valid, rd_top, rd_bot});
    end
    tick();
    tick();
    reset = 1'b1;
    #2;
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready_before_edge: got %b required 0", wr_ready);
    end
    tick();
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready_after_edge: got %b required 1", wr_ready);
    end
    $display("reset released, wr_ready=%b", wr_ready);
  endtask

  task automatic test_clear_swap();
    int n;
    clr_req = 1'b1;
    clr_rgb = 3'b001;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    n_checks++;
    if (n != 1024) begin
      n_errors++;
      $display("FAIL clear_length: got %0d cycles required 1024", n);
    end
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL clear_ready_after: got %b required 1", wr_ready);
    end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    n_checks++;
    if ({swap_pending, wr_ready, front_sel} !== 3'b100) begin
      n_errors++;
      $display("FAIL swap_wait_state: got pend/ready/front=%b required 100", {swap_pending, wr_ready, front_sel});
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++;
    if ({swap_pending, wr_ready, front_sel} !== 3'b011) begin
      n_errors++;
      $display("FAIL swap_applied: got pend/ready/front=%b required 011", {swap_pending, wr_ready, front_sel});
    end
    do_read(4'd0, 6'd0);
    n_checks++;
    if ({rd_valid, rd_top, rd_bot} !== 7'b1_001_001) begin
      n_errors++;
      $display("FAIL clear_read: got valid/top/bot=%b required 1001001", {rd_valid, rd_top, rd_bot});
    end
    tick();
    n_checks++;
    if ({rd_valid, rd_top, rd_bot} !== 7'b0_001_001) begin
      n_errors++;
      $display("FAIL read_hold: got valid/top/bot=%b required 0001001", {rd_valid, rd_top, rd_bot});
    end
  endtask

  task automatic test_write_read();
    wr_valid = 1'b1;
    wr_x = 6'd5; wr_y = 5'd3;  wr_rgb = 3'b110;
    tick();
    wr_x = 6'd5; wr_y = 5'd19; wr_rgb = 3'b011;
    tick();
    wr_valid = 1'b0;
    $display("write (5,3)=110 and (5,19)=011");
    do_swap();
    n_checks++;
    if (front_sel !== 1'b0) begin
      n_errors++;
      $display("FAIL write_swap_front: got %b required 0", front_sel);
    end
    do_read(4'd3, 6'd5);
    n_checks++;
    if ({rd_valid, rd_top, rd_bot} !== 7'b1_110_011) begin
      n_errors++;
      $display("FAIL write_read: got valid/top/bot=%b required 1110011", {rd_valid, rd_top, rd_bot});
    end
  endtask

  task automatic test_swap_stall();
    int bad;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    wr_valid = 1'b1;
    wr_x = 6'd10; wr_y = 5'd7; wr_rgb = 3'b101;
    bad = 0;
    repeat (100) begin
      if (wr_ready !== 1'b0 || swap_pending !== 1'b1 || front_sel !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL stall_hold: got %0d bad cycles required 0", bad);
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++;
    if ({front_sel, wr_ready, swap_pending} !== 3'b110) begin
      n_errors++;
      $display("FAIL stall_release: got front/ready/pend=%b required 110", {front_sel, wr_ready, swap_pending});
    end
    tick();  // held write accepted into bank 0
    wr_valid = 1'b0;
    $display("held write (10,7)=101 released");
    do_swap();
    do_read(4'd7, 6'd10);
    n_checks++;
    if ({rd_valid, rd_top} !== 4'b1_101) begin
      n_errors++;
      $display("FAIL stall_write_read: got valid/top=%b required 1101", {rd_valid, rd_top});
    end
    do_swap();
    do_read(4'd7, 6'd10);
    n_checks++;
    if (rd_top !== 3'b001) begin
      n_errors++;
      $display("FAIL stall_no_early_write: got %b required 001", rd_top);
    end
  endtask

  task automatic test_same_cycle_swap();
    // front_sel is 1 here
    swap_req  = 1'b1;
    frame_end = 1'b1;
    tick();
    swap_req  = 1'b0;
    frame_end = 1'b0;
    n_checks++;
    if ({front_sel, swap_pending} !== 2'b11) begin
      n_errors++;
      $display("FAIL same_cycle_no_toggle: got front/pend=%b required 11", {front_sel, swap_pending});
    end
    tick();
    tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++;
    if ({front_sel, swap_pending} !== 2'b00) begin
      n_errors++;
      $display("FAIL same_cycle_next_toggle: got front/pend=%b required 00", {front_sel, swap_pending});
    end
    $display("same-cycle swap_req/frame_end, front_sel=%b", front_sel);
    do_swap();  // back to front_sel=1 so bank 0 is the back bank
  endtask

  task automatic test_swap_during_clear();
    int n;
    clr_req = 1'b1;
    clr_rgb = 3'b100;
    tick();
    clr_req = 1'b0;
    n = 0;
    repeat (300) begin
      if (clr_busy === 1'b1) n++;
      tick();
    end
    swap_req = 1'b1;
    if (clr_busy === 1'b1) n++;
    tick();
    swap_req = 1'b0;
    n_checks++;
    if ({swap_pending, clr_busy} !== 2'b11) begin
      n_errors++;
      $display("FAIL clear_swap_latched: got pend/busy=%b required 11", {swap_pending, clr_busy});
    end
    while (clr_busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    n_checks++;
    if (n != 1024) begin
      n_errors++;
      $display("FAIL clear_swap_length: got %0d cycles required 1024", n);
    end
    repeat (5) tick();
    n_checks++;
    if ({wr_ready, swap_pending, front_sel} !== 3'b011) begin
      n_errors++;
      $display("FAIL clear_then_wait: got ready/pend/front=%b required 011", {wr_ready, swap_pending, front_sel});
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++;
    if ({front_sel, wr_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL clear_swap_applied: got front/ready=%b required 01", {front_sel, wr_ready});
    end
    do_read(4'd15, 6'd63);
    n_checks++;
    if ({rd_top, rd_bot} !== 6'b100_100) begin
      n_errors++;
      $display("FAIL clear_last_word: got top/bot=%b required 100100", {rd_top, rd_bot});
    end
    do_read(4'd3, 6'd5);
    n_checks++;
    if ({rd_top, rd_bot} !== 6'b100_100) begin
      n_errors++;
      $display("FAIL clear_overwrites: got top/bot=%b required 100100", {rd_top, rd_bot});
    end
  endtask

  task automatic test_reset_mid_clear();
    do_swap();  // front_sel=1, rd_top holds 100 from the last read
    clr_req = 1'b1;
    clr_rgb = 3'b010;
    tick();
    clr_req = 1'b0;
    repeat (500) tick();
    n_checks++;
    if ({clr_busy, front_sel} !== 2'b11) begin
      n_errors++;
      $display("FAIL mid_clear_state: got busy/front=%b required 11", {clr_busy, front_sel});
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({wr_ready, clr_busy, swap_pending, front_sel, rd_valid, rd_top, rd_bot} !== 11'b0) begin
      n_errors++;
      $display("FAIL mid_clear_reset: got %b required 0", {wr_ready, clr_busy, swap_pending, front_sel, rd_valid, rd_top, rd_bot});
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_clear_ready_before: got %b required 0", wr_ready);
    end
    tick();
    n_checks++;
    if ({wr_ready, clr_busy} !== 2'b10) begin
      n_errors++;
      $display("FAIL mid_clear_ready_after: got ready/busy=%b required 10", {wr_ready, clr_busy});
    end
    $display("reset during fill, recovered wr_ready=%b", wr_ready);
  endtask

  initial begin
    reset = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
    clr_req = 1'b0; clr_rgb = '0; swap_req = 1'b0; frame_end = 1'b0;
    rd_en = 1'b0; rd_row = '0; rd_col = '0;
    test_reset();
    test_clear_swap();
    test_write_read();
    test_swap_stall();
    test_same_cycle_swap();
    test_swap_during_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
